// File: rtl/fft_r2sdf_stage.sv
// fft_r2sdf_stage: radix-2 SDF DIF FFT stage; define FFT_SDF_SAT_EN to saturate reductions instead of wrapping
module fft_r2sdf_stage #(
    parameter int DW    = 16,
    parameter int N     = 16,
    parameter int STAGE = 1,
    parameter int SCALE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic [2*DW-1:0] in_data,
    output logic            out_valid,
    output logic            out_sof,
    output logic [2*DW-1:0] out_data
);
    localparam int D  = N >> (STAGE + 1);
    localparam int CW = $clog2(2 * D);
    localparam int PW = $clog2(D + 1);
    localparam int WW = DW + 4;
    localparam int WM = DW + 20;
    localparam int TS = $clog2(64 / N) + STAGE;
`ifdef FFT_SDF_SAT_EN
    localparam logic signed [WW-1:0] SMAX = WW'((1 << (DW - 1)) - 1);
    localparam logic signed [WW-1:0] SMIN = -SMAX - 1;
`endif

    function automatic logic signed [17:0] qc(input logic [4:0] k);
        case (k)
            5'd0:    return 18'sd65536;
            5'd1:    return 18'sd65220;
            5'd2:    return 18'sd64277;
            5'd3:    return 18'sd62714;
            5'd4:    return 18'sd60547;
            5'd5:    return 18'sd57798;
            5'd6:    return 18'sd54491;
            5'd7:    return 18'sd50660;
            5'd8:    return 18'sd46341;
            5'd9:    return 18'sd41576;
            5'd10:   return 18'sd36410;
            5'd11:   return 18'sd30893;
            5'd12:   return 18'sd25080;
            5'd13:   return 18'sd19024;
            5'd14:   return 18'sd12785;
            5'd15:   return 18'sd6424;
            default: return 18'sd0;
        endcase
    endfunction

    function automatic logic signed [DW:0] scl(input logic signed [DW:0] v);
        logic signed [DW+1:0] t;
        t = {v[DW], v} + (DW + 2)'(1);
        return (SCALE != 0) ? t[DW+1:1] : v;
    endfunction

    function automatic logic [DW-1:0] red(input logic signed [WW-1:0] v);
`ifdef FFT_SDF_SAT_EN
        return (v > SMAX) ? SMAX[DW-1:0] : (v < SMIN) ? SMIN[DW-1:0] : v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction

    logic [CW-1:0] cnt_q, cnt_d, idx, idx_lo;
    logic [PW-1:0] prime_q, prime_d;
    logic [D-1:0] sof_q, sof_d;
    logic [2*DW-1:0] fifo_q [D];
    logic [2*DW-1:0] fifo_d [D];
    logic acc, ph_b, primed;
    logic [4:0] k;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [DW:0] sr, si, dr, di;
    logic signed [17:0] wr, wi;
    logic [2*DW-1:0] push;
    logic s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
    logic signed [DW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    logic signed [17:0] s1_wr_q, s1_wr_d, s1_wi_q, s1_wi_d;
    logic signed [WM-1:0] pr, pi;
    logic out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic [2*DW-1:0] out_data_q, out_data_d;

    // counter, priming, sof delay line, butterfly/mux, twiddle lookup and FIFO shift
    always_comb begin
        acc = in_valid && !rst;
        idx = in_sof ? '0 : cnt_q;
        idx_lo = idx & CW'(D - 1);
        ph_b = idx[CW-1];
        primed = prime_q == PW'(D);
        cnt_d = acc ? idx + 1'b1 : cnt_q;
        prime_d = (acc && !primed) ? prime_q + 1'b1 : prime_q;
        sof_d = acc ? D'({sof_q, in_sof}) : sof_q;
        k = 5'({{(32 - CW){1'b0}}, idx_lo} << TS);
        wr = (k <= 5'd16) ? qc(k) : -qc(5'd0 - k);
        wi = (k <= 5'd16) ? -qc(5'd16 - k) : -qc(k - 5'd16);
        {ar, ai} = fifo_q[D-1];
        {br, bi} = in_data;
        sr = scl((DW + 1)'(ar) + (DW + 1)'(br));
        si = scl((DW + 1)'(ai) + (DW + 1)'(bi));
        dr = scl((DW + 1)'(ar) - (DW + 1)'(br));
        di = scl((DW + 1)'(ai) - (DW + 1)'(bi));
        push = ph_b ? {red(WW'(dr)), red(WW'(di))} : in_data;
        fifo_d[0] = acc ? push : fifo_q[0];
        for (int i = 1; i < D; i++) fifo_d[i] = acc ? fifo_q[i-1] : fifo_q[i];
        s1_valid_d = acc && primed;
        s1_sof_d = acc && primed && sof_q[D-1];
        s1_re_d = ph_b ? red(WW'(sr)) : ar;
        s1_im_d = ph_b ? red(WW'(si)) : ai;
        s1_wr_d = ph_b ? 18'sh10000 : wr;
        s1_wi_d = ph_b ? 18'sh00000 : wi;
    end

    // complex twiddle multiply with round-half-up back to Q0
    always_comb begin
        pr = WM'(s1_re_q) * WM'(s1_wr_q) - WM'(s1_im_q) * WM'(s1_wi_q);
        pi = WM'(s1_re_q) * WM'(s1_wi_q) + WM'(s1_im_q) * WM'(s1_wr_q);
        pr = (pr + WM'(32768)) >>> 16;
        pi = (pi + WM'(32768)) >>> 16;
        out_valid_d = s1_valid_q;
        out_sof_d = s1_sof_q;
        out_data_d = {red(WW'(pr)), red(WW'(pi))};
    end

    // control and pipeline registers; rst drops any concurrent sample
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            prime_q <= '0;
            sof_q <= '0;
            s1_valid_q <= 1'b0;
            s1_sof_q <= 1'b0;
            s1_re_q <= '0;
            s1_im_q <= '0;
            s1_wr_q <= '0;
            s1_wi_q <= '0;
            out_valid_q <= 1'b0;
            out_sof_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            prime_q <= prime_d;
            sof_q <= sof_d;
            s1_valid_q <= s1_valid_d;
            s1_sof_q <= s1_sof_d;
            s1_re_q <= s1_re_d;
            s1_im_q <= s1_im_d;
            s1_wr_q <= s1_wr_d;
            s1_wi_q <= s1_wi_d;
            out_valid_q <= out_valid_d;
            out_sof_q <= out_sof_d;
            out_data_q <= out_data_d;
        end
    end

    // feedback FIFO storage is never reset; priming hides stale entries
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign out_valid = out_valid_q;
    assign out_sof = out_sof_q;
    assign out_data = out_data_q;
endmodule
